// File: rtl/fifo_uart_tx.sv
`default_nettype none
// ============================================================================
//  Module   : fifo_uart_tx
//  Purpose  : Pops words from an upstream fifo through a four-phase receive
//             handshake and sends each one as an asynchronous UART frame
//             (start, WIDTH data bits LSB first, optional even parity,
//             STOP_BITS stop bits). Drains the fifo back-to-back while
//             enable is high.
//  Ports    : clk        system clock, rising edge
//             rst_n      asynchronous active-low reset
//             enable     permission to fetch a new word (looked at in IDLE only)
//             fifo_rdy   fifo word available; fifo_data valid while high
//             fifo_data  fifo output word
//             fifo_done  pop acknowledge back to the fifo
//             tx         registered serial line, idle high
//             busy       high whenever the engine is not idle
//             frame_cnt  frames completed since reset, wraps at 16 bits
//  Revision : 1.0 - initial release
// ============================================================================
module fifo_uart_tx #(
  parameter int WIDTH        = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_EN    = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             fifo_rdy,
  input  logic [WIDTH-1:0] fifo_data,
  output logic             fifo_done,
  output logic             tx,
  output logic             busy,
  output logic [15:0]      frame_cnt
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [CW-1:0] C_BAUD_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] C_BIT_LAST  = BW'(WIDTH - 1);
  localparam logic          C_STOP_LAST = 1'(STOP_BITS - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_START  = 3'd2;
  localparam logic [2:0] S_DATA   = 3'd3;
  localparam logic [2:0] S_PARITY = 3'd4;
  localparam logic [2:0] S_STOP   = 3'd5;

  logic [2:0]       r_state;
  logic [2:0]       w_state_dec;
  logic [2:0]       w_state_nxt;

  logic [WIDTH-1:0] r_shift;
  logic             r_parity;
  logic [CW-1:0]    r_baud;
  logic [BW-1:0]    r_bit_idx;
  logic             r_stop_idx;
  logic             r_tx;
  logic             r_done;
  logic [15:0]      r_frame_cnt;

  logic [WIDTH-1:0] w_shift_nxt;
  logic             w_parity_nxt;
  logic [CW-1:0]    w_baud_nxt;
  logic [BW-1:0]    w_bit_idx_nxt;
  logic             w_stop_idx_nxt;
  logic             w_tx_nxt;
  logic             w_done_nxt;
  logic             w_frame_inc;
  logic             w_baud_end;

  // Encodings 6 and 7 are never entered; treat them as IDLE everywhere.
  always_comb begin
    w_state_dec = S_IDLE;
    case (r_state)
      S_IDLE, S_FETCH, S_START, S_DATA, S_PARITY, S_STOP: w_state_dec = r_state;
      default:                                            w_state_dec = S_IDLE;
    endcase
  end

  assign w_baud_end = (r_baud == C_BAUD_LAST);

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = w_state_dec;
    case (w_state_dec)
      S_IDLE: begin
        if (enable && fifo_rdy) w_state_nxt = S_FETCH;
      end
      S_FETCH: begin
        // Four-phase ack: the fifo drops rdy once it has seen done.
        if (!fifo_rdy) w_state_nxt = S_START;
      end
      S_START: begin
        if (w_baud_end) w_state_nxt = S_DATA;
      end
      S_DATA: begin
        if (w_baud_end && (r_bit_idx == C_BIT_LAST)) begin
          w_state_nxt = (PARITY_EN != 0) ? S_PARITY : S_STOP;
        end
      end
      S_PARITY: begin
        if (w_baud_end) w_state_nxt = S_STOP;
      end
      S_STOP: begin
        if (w_baud_end && (r_stop_idx == C_STOP_LAST)) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Output / datapath next values
  // --------------------------------------------------------------------------
  always_comb begin
    w_shift_nxt    = r_shift;
    w_parity_nxt   = r_parity;
    w_baud_nxt     = r_baud + CW'(1);
    w_bit_idx_nxt  = '0;
    w_stop_idx_nxt = 1'b0;
    w_tx_nxt       = 1'b1;
    w_done_nxt     = (w_state_nxt == S_FETCH);
    w_frame_inc    = (w_state_dec == S_STOP) && (w_state_nxt == S_IDLE);

    // Latch the word and its parity on the same edge that raises done.
    if ((w_state_dec == S_IDLE) && (w_state_nxt == S_FETCH)) begin
      w_shift_nxt  = fifo_data;
      w_parity_nxt = ^fifo_data;
    end else if ((w_state_dec == S_DATA) && w_baud_end) begin
      w_shift_nxt = r_shift >> 1;
    end

    // Baud counter restarts at every bit boundary and is parked while the
    // line is not being driven with frame content.
    if (w_baud_end || (w_state_nxt != w_state_dec) ||
        (w_state_dec == S_IDLE) || (w_state_dec == S_FETCH)) begin
      w_baud_nxt = '0;
    end

    if (w_state_dec == S_DATA) begin
      w_bit_idx_nxt = r_bit_idx;
      if (w_baud_end) begin
        w_bit_idx_nxt = (r_bit_idx == C_BIT_LAST) ? '0 : r_bit_idx + BW'(1);
      end
    end

    if (w_state_dec == S_STOP) begin
      w_stop_idx_nxt = r_stop_idx;
      if (w_baud_end) begin
        w_stop_idx_nxt = (r_stop_idx == C_STOP_LAST) ? 1'b0 : r_stop_idx + 1'b1;
      end
    end

    // tx is a function of the state being entered, so the register only
    // changes at bit boundaries. The shift register's LSB is always the
    // bit on the wire during DATA.
    case (w_state_nxt)
      S_START:  w_tx_nxt = 1'b0;
      S_DATA:   w_tx_nxt = w_shift_nxt[0];
      S_PARITY: w_tx_nxt = r_parity;
      default:  w_tx_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shift     <= '0;
      r_parity    <= 1'b0;
      r_baud      <= '0;
      r_bit_idx   <= '0;
      r_stop_idx  <= 1'b0;
      r_tx        <= 1'b1;
      r_done      <= 1'b0;
      r_frame_cnt <= 16'd0;
    end else begin
      r_shift    <= w_shift_nxt;
      r_parity   <= w_parity_nxt;
      r_baud     <= w_baud_nxt;
      r_bit_idx  <= w_bit_idx_nxt;
      r_stop_idx <= w_stop_idx_nxt;
      r_tx       <= w_tx_nxt;
      r_done     <= w_done_nxt;
      if (w_frame_inc) begin
        r_frame_cnt <= r_frame_cnt + 16'd1;
      end
    end
  end

  assign tx        = r_tx;
  assign fifo_done = r_done;
  assign busy      = (w_state_dec != S_IDLE);
  assign frame_cnt = r_frame_cnt;

endmodule
`default_nettype wire

// File: tb/tb_fifo_uart_tx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fifo_uart_tx
//  Purpose  : Self-checking bench for fifo_uart_tx. Three instances cover the
//             frame formats: [0] plain 8N1, [1] even parity + 1 stop,
//             [2] no parity + 2 stops, all at 4 clocks per bit. A queue-based
//             fifo model drives the four-phase pop handshake of each one.
//  Ports    : none
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_uart_tx;

  localparam int CPB = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  en = '0;
  logic [2:0]  rdy = '0;
  logic [7:0]  fdata [3] = '{default: 8'h00};
  logic [2:0]  fdone;
  logic [2:0]  tx;
  logic [2:0]  busy;
  logic [15:0] fcnt [3];

  always #5 clk = ~clk;

  fifo_uart_tx #(.WIDTH(8), .CLKS_PER_BIT(CPB), .PARITY_EN(0), .STOP_BITS(1)) u_a (
    .clk(clk), .rst_n(rst_n), .enable(en[0]), .fifo_rdy(rdy[0]), .fifo_data(fdata[0]),
    .fifo_done(fdone[0]), .tx(tx[0]), .busy(busy[0]), .frame_cnt(fcnt[0]));
  fifo_uart_tx #(.WIDTH(8), .CLKS_PER_BIT(CPB), .PARITY_EN(1), .STOP_BITS(1)) u_b (
    .clk(clk), .rst_n(rst_n), .enable(en[1]), .fifo_rdy(rdy[1]), .fifo_data(fdata[1]),
    .fifo_done(fdone[1]), .tx(tx[1]), .busy(busy[1]), .frame_cnt(fcnt[1]));
  fifo_uart_tx #(.WIDTH(8), .CLKS_PER_BIT(CPB), .PARITY_EN(0), .STOP_BITS(2)) u_c (
    .clk(clk), .rst_n(rst_n), .enable(en[2]), .fifo_rdy(rdy[2]), .fifo_data(fdata[2]),
    .fifo_done(fdone[2]), .tx(tx[2]), .busy(busy[2]), .frame_cnt(fcnt[2]));

  int tests_run = 0;
  int failed = 0;
  int exp_cnt [3] = '{0, 0, 0};
  int pulses [3] = '{0, 0, 0};
  logic [2:0] done_prev = '0;

  // ---------------- upstream fifo model ----------------
  logic [7:0] q0[$];
  logic [7:0] q1[$];
  logic [7:0] q2[$];

  function automatic int qsize(input int i);
    case (i)
      0: return q0.size();
      1: return q1.size();
      default: return q2.size();
    endcase
  endfunction

  function automatic logic [7:0] qfront(input int i);
    case (i)
      0: return q0[0];
      1: return q1[0];
      default: return q2[0];
    endcase
  endfunction

  function automatic void qpop(input int i);
    case (i)
      0: void'(q0.pop_front());
      1: void'(q1.pop_front());
      default: void'(q2.pop_front());
    endcase
  endfunction

  function automatic void qpush(input int i, input logic [7:0] w);
    case (i)
      0: q0.push_back(w);
      1: q1.push_back(w);
      default: q2.push_back(w);
    endcase
  endfunction

  // Four-phase handshake: present head word, pop on done, wait for done low.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (fdone[i] && !done_prev[i]) pulses[i]++;
      done_prev[i] = fdone[i];
      if (rdy[i] && fdone[i]) begin
        qpop(i);
        rdy[i] = 1'b0;
        fdata[i] = 8'($urandom);
      end else if (!rdy[i] && !fdone[i] && qsize(i) > 0) begin
        rdy[i] = 1'b1;
        fdata[i] = qfront(i);
      end
    end
  end

  // ---------------- reference model ----------------
  function automatic int par_of(input int i);
    return (i == 1) ? 1 : 0;
  endfunction

  function automatic int stp_of(input int i);
    return (i == 2) ? 2 : 1;
  endfunction

  // Per-cycle expected line level from the first start-bit cycle onward.
  function automatic logic [63:0] exp_wave(input logic [7:0] w, input int par,
                                           input int stp, output int len);
    logic [15:0] bits;
    logic [63:0] wv;
    int nb;
    bits = '1;
    bits[0] = 1'b0;
    for (int k = 0; k < 8; k++) bits[k+1] = w[k];
    nb = 9;
    if (par != 0) begin
      bits[nb] = ^w;
      nb++;
    end
    nb += stp;
    wv = '0;
    for (int b = 0; b < nb; b++)
      for (int c = 0; c < CPB; c++) wv[b*CPB+c] = bits[b];
    len = nb * CPB;
    return wv;
  endfunction

  // Records tx every cycle from the first low sample until busy drops.
  task automatic capture(input int i, output logic [63:0] wave, output int len, output bit to);
    int n;
    wave = '0;
    len = 0;
    to = 1'b0;
    n = 0;
    while (tx[i] !== 1'b0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (tx[i] !== 1'b0) begin
      to = 1'b1;
      return;
    end
    while (busy[i] === 1'b1 && len < 64) begin
      wave[len] = tx[i];
      len++;
      @(negedge clk);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    rst_n = 1'b0;
    en = '0;
    repeat (3) @(negedge clk);
    tests_run++;
    if ({tx, busy, fdone} !== 9'b111_000_000) begin
      failed++;
      $display("FAIL reset_held tx/busy/done got %b want %b", {tx, busy, fdone}, 9'b111_000_000);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    tests_run++;
    if ({tx, busy, fdone} !== 9'b111_000_000) begin
      failed++;
      $display("FAIL reset_release tx/busy/done got %b want %b", {tx, busy, fdone}, 9'b111_000_000);
    end
    for (int i = 0; i < 3; i++) begin
      tests_run++;
      if (fcnt[i] !== 16'd0) begin
        failed++;
        $display("FAIL reset_frame_cnt[%0d] got %0d want 0", i, fcnt[i]);
      end
    end
  endtask

  task automatic test_single;
    logic [63:0] wv, ew;
    int len, el;
    bit to;
    qpush(0, 8'hA5);
    en[0] = 1'b1;
    capture(0, wv, len, to);
    ew = exp_wave(8'hA5, 0, 1, el);
    exp_cnt[0]++;
    tests_run++;
    if (to || wv !== ew || len != el) begin
      failed++;
      $display("FAIL single_frame to=%0d wave=%h len=%0d want wave=%h len=%0d", to, wv, len, ew, el);
    end
    repeat (3) @(negedge clk);
    tests_run++;
    if (fcnt[0] !== 16'(exp_cnt[0]) || qsize(0) != 0) begin
      failed++;
      $display("FAIL single_cnt frame_cnt=%0d q=%0d want %0d q=0", fcnt[0], qsize(0), exp_cnt[0]);
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] words [5];
    logic [63:0] wv, ew;
    int len, el, p0;
    bit to;
    p0 = pulses[0];
    for (int k = 0; k < 5; k++) begin
      words[k] = 8'($urandom);
      qpush(0, words[k]);
    end
    for (int k = 0; k < 5; k++) begin
      capture(0, wv, len, to);
      ew = exp_wave(words[k], 0, 1, el);
      exp_cnt[0]++;
      tests_run++;
      if (to || wv !== ew || len != el) begin
        failed++;
        $display("FAIL b2b_frame%0d to=%0d wave=%h len=%0d want wave=%h len=%0d", k, to, wv, len, ew, el);
      end
    end
    repeat (3) @(negedge clk);
    tests_run++;
    if (pulses[0] - p0 != 5 || fcnt[0] !== 16'(exp_cnt[0]) || qsize(0) != 0) begin
      failed++;
      $display("FAIL b2b_totals pops=%0d cnt=%0d q=%0d want pops=5 cnt=%0d q=0",
               pulses[0] - p0, fcnt[0], qsize(0), exp_cnt[0]);
    end
  endtask

  task automatic test_parity;
    logic [7:0] words [4];
    logic [63:0] wv, ew;
    int len, el;
    bit to;
    words[0] = 8'hA5;
    words[1] = 8'h07;
    words[2] = 8'($urandom);
    words[3] = 8'($urandom);
    for (int k = 0; k < 4; k++) qpush(1, words[k]);
    en[1] = 1'b1;
    for (int k = 0; k < 4; k++) begin
      capture(1, wv, len, to);
      ew = exp_wave(words[k], 1, 1, el);
      exp_cnt[1]++;
      tests_run++;
      if (to || wv !== ew || len != el) begin
        failed++;
        $display("FAIL parity_frame%0d to=%0d wave=%h len=%0d want wave=%h len=%0d", k, to, wv, len, ew, el);
      end
      tests_run++;
      if (wv[9*CPB] !== ^words[k]) begin
        failed++;
        $display("FAIL parity_bit%0d got %b want %b", k, wv[9*CPB], ^words[k]);
      end
    end
    repeat (3) @(negedge clk);
    tests_run++;
    if (fcnt[1] !== 16'(exp_cnt[1])) begin
      failed++;
      $display("FAIL parity_cnt got %0d want %0d", fcnt[1], exp_cnt[1]);
    end
  endtask

  task automatic test_enable_drop;
    logic [7:0] words [3];
    logic [63:0] wv, ew;
    int len, el, n, bad;
    bit to;
    en[0] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      words[k] = 8'($urandom);
      qpush(0, words[k]);
    end
    repeat (3) @(negedge clk);
    en[0] = 1'b1;
    n = 0;
    while (busy[0] !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    en[0] = 1'b0;
    capture(0, wv, len, to);
    ew = exp_wave(words[0], 0, 1, el);
    exp_cnt[0]++;
    tests_run++;
    if (to || wv !== ew || len != el) begin
      failed++;
      $display("FAIL endrop_frame0 to=%0d wave=%h len=%0d want wave=%h len=%0d", to, wv, len, ew, el);
    end
    bad = 0;
    for (int c = 0; c < 60; c++) begin
      if (tx[0] !== 1'b1 || busy[0] !== 1'b0 || fdone[0] !== 1'b0) bad++;
      @(negedge clk);
    end
    tests_run++;
    if (bad != 0 || qsize(0) != 2) begin
      failed++;
      $display("FAIL endrop_idle bad_cycles=%0d q=%0d want 0 and 2", bad, qsize(0));
    end
    en[0] = 1'b1;
    for (int k = 1; k < 3; k++) begin
      capture(0, wv, len, to);
      ew = exp_wave(words[k], 0, 1, el);
      exp_cnt[0]++;
      tests_run++;
      if (to || wv !== ew || len != el) begin
        failed++;
        $display("FAIL endrop_frame%0d to=%0d wave=%h len=%0d want wave=%h len=%0d", k, to, wv, len, ew, el);
      end
    end
    repeat (3) @(negedge clk);
    tests_run++;
    if (fcnt[0] !== 16'(exp_cnt[0]) || qsize(0) != 0) begin
      failed++;
      $display("FAIL endrop_cnt cnt=%0d q=%0d want %0d q=0", fcnt[0], qsize(0), exp_cnt[0]);
    end
  endtask

  task automatic test_stop2_idle;
    logic [63:0] wv, ew;
    int len, el, bad;
    bit to;
    en[2] = 1'b1;
    bad = 0;
    for (int c = 0; c < 100; c++) begin
      if (tx[2] !== 1'b1 || busy[2] !== 1'b0 || fdone[2] !== 1'b0) bad++;
      @(negedge clk);
    end
    tests_run++;
    if (bad != 0) begin
      failed++;
      $display("FAIL empty_idle bad_cycles=%0d want 0", bad);
    end
    qpush(2, 8'hFF);
    capture(2, wv, len, to);
    ew = exp_wave(8'hFF, 0, 2, el);
    exp_cnt[2]++;
    tests_run++;
    if (to || wv !== ew || len != el) begin
      failed++;
      $display("FAIL stop2_frame to=%0d wave=%h len=%0d want wave=%h len=%0d", to, wv, len, ew, el);
    end
  endtask

  task automatic test_random;
    logic [63:0] wv, ew;
    logic [7:0] w;
    int len, el, i;
    bit to;
    for (int k = 0; k < 9; k++) begin
      i = k % 3;
      w = 8'($urandom);
      en[i] = 1'b1;
      qpush(i, w);
      capture(i, wv, len, to);
      ew = exp_wave(w, par_of(i), stp_of(i), el);
      exp_cnt[i]++;
      tests_run++;
      if (to || wv !== ew || len != el) begin
        failed++;
        $display("FAIL random_frame%0d inst%0d to=%0d wave=%h len=%0d want wave=%h len=%0d",
                 k, i, to, wv, len, ew, el);
      end
      @(negedge clk);
      tests_run++;
      if (fcnt[i] !== 16'(exp_cnt[i])) begin
        failed++;
        $display("FAIL random_cnt%0d inst%0d got %0d want %0d", k, i, fcnt[i], exp_cnt[i]);
      end
    end
  endtask

  task automatic test_reset_mid_frame;
    logic [63:0] wv, ew;
    logic [7:0] w1, w2;
    int len, el, n;
    bit to;
    w1 = 8'($urandom);
    w2 = 8'($urandom);
    qpush(0, w1);
    qpush(0, w2);
    en[0] = 1'b1;
    n = 0;
    while (tx[0] !== 1'b0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    tests_run++;
    if (tx[0] !== 1'b0) begin
      failed++;
      $display("FAIL rstmid_start got tx=%b want 0 within 100 cycles", tx[0]);
    end
    // Sample 17 after the first start cycle lies inside data bit 3.
    repeat (17) @(negedge clk);
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (tx[0] !== 1'b1 || busy[0] !== 1'b0 || fdone[0] !== 1'b0 || fcnt[0] !== 16'd0) begin
      failed++;
      $display("FAIL rstmid_async tx=%b busy=%b done=%b cnt=%0d want 1 0 0 0",
               tx[0], busy[0], fdone[0], fcnt[0]);
    end
    exp_cnt = '{0, 0, 0};
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    capture(0, wv, len, to);
    ew = exp_wave(w2, 0, 1, el);
    exp_cnt[0]++;
    tests_run++;
    if (to || wv !== ew || len != el) begin
      failed++;
      $display("FAIL rstmid_next to=%0d wave=%h len=%0d want wave=%h len=%0d", to, wv, len, ew, el);
    end
    repeat (3) @(negedge clk);
    tests_run++;
    if (fcnt[0] !== 16'(exp_cnt[0]) || qsize(0) != 0) begin
      failed++;
      $display("FAIL rstmid_cnt cnt=%0d q=%0d want %0d q=0", fcnt[0], qsize(0), exp_cnt[0]);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_parity();
    test_enable_drop();
    test_stop2_idle();
    test_random();
    test_reset_mid_frame();
    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule
`default_nettype wire
